// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling with a one-cycle byte strobe.
// Revision: 1.0
`default_nettype none

module uart_rx #(
    parameter int c_CYCLES_PER_BIT = 434
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_SERIAL_DATA,
    output logic [7:0] o_DATA_RX,
    output logic       o_RX_DATA_VALID,
    output logic       o_FRAME_ERR
);

    localparam int CW = $clog2(c_CYCLES_PER_BIT);
    localparam logic [CW-1:0] c_LAST = CW'(c_CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] c_HALF = CW'((c_CYCLES_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic            r_armed;
    logic            w_bit_done;
    logic            w_stop_sample;

    assign w_bit_done    = (r_cnt == c_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_bit_done;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_SERIAL_DATA;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s && r_armed) w_next_state = S_START;
            end
            S_START: begin
                if (r_cnt == c_HALF) w_next_state = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_bit_done) w_next_state = S_CLEANUP;
            end
            S_CLEANUP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change and on each data-bit sample.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) || (r_state == S_IDLE) ||
                     ((r_state == S_DATA) && w_bit_done)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_bit_idx <= 3'd0;
            o_DATA_RX <= 8'h00;
        end else if (r_state == S_START) begin
            r_bit_idx <= 3'd0;
        end else if ((r_state == S_DATA) && w_bit_done) begin
            o_DATA_RX[r_bit_idx] <= r_rx_s;
            r_bit_idx            <= r_bit_idx + 3'd1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_RX_DATA_VALID <= 1'b0;
            o_FRAME_ERR     <= 1'b0;
        end else begin
            o_RX_DATA_VALID <= w_stop_sample && r_rx_s;
            o_FRAME_ERR     <= w_stop_sample && !r_rx_s;
        end
    end

    // A frame error disarms the receiver until the line returns high, so a
    // held-low break produces one error rather than a stream of null frames.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_armed <= 1'b1;
        end else if (w_stop_sample && !r_rx_s) begin
            r_armed <= 1'b0;
        end else if (r_rx_s) begin
            r_armed <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed stimulus with an expected-event queue for uart_rx.
// Revision: 1.0
`default_nettype none

module tb_uart_rx;

    localparam int CPB   = 217;
    localparam int BIT_NS = 8680;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial;
    logic [7:0] data;
    logic       valid;
    logic       ferr;

    int compared   = 0;
    int mismatched = 0;
    ev_t q[$];

    uart_rx #(.c_CYCLES_PER_BIT(CPB)) dut (
        .i_CLK          (clk),
        .i_RST_N        (rst_n),
        .i_SERIAL_DATA  (serial),
        .o_DATA_RX      (data),
        .o_RX_DATA_VALID(valid),
        .o_FRAME_ERR    (ferr)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int start_extra_ns, input logic stop_val);
        serial = 1'b0;
        #(BIT_NS + start_extra_ns);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            #(BIT_NS);
        end
        serial = stop_val;
        #(BIT_NS);
        serial = 1'b1;
    endtask

    // Scoreboard: every strobe pops one expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (valid === 1'b1 || ferr === 1'b1)) begin
            ev_t exp_ev;
            check("strobe_exclusive", {31'd0, valid & ferr}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_strobe", {23'd0, ferr, data}, 32'hFFFF_FFFF);
            end else begin
                exp_ev = q.pop_front();
                check("rx_event", {23'd0, ferr, data}, {23'd0, exp_ev.err, exp_ev.data});
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        serial = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        rst_n = 1'b1;
        #(BIT_NS);

        // Stretched start bit
        q.push_back('{err: 1'b0, data: 8'h26});
        send_byte(8'h26, 1000, 1'b1);
        @(posedge clk);
        #1;
        check("data_after_stop", {24'd0, data}, 32'h26);
        #(BIT_NS);

        // Back-to-back frames
        q.push_back('{err: 1'b0, data: 8'h00});
        q.push_back('{err: 1'b0, data: 8'hFF});
        q.push_back('{err: 1'b0, data: 8'hA5});
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'hFF, 0, 1'b1);
        send_byte(8'hA5, 0, 1'b1);
        #(2 * BIT_NS);
        check("b2b_drained", q.size(), 0);

        // Short low glitch must be rejected
        serial = 1'b0;
        #2000;
        serial = 1'b1;
        #(12 * BIT_NS);
        check("glitch_data_held", {24'd0, data}, 32'hA5);

        // Framing error then recovery
        q.push_back('{err: 1'b1, data: 8'h3C});
        send_byte(8'h3C, 0, 1'b0);
        #(BIT_NS);
        q.push_back('{err: 1'b0, data: 8'h11});
        send_byte(8'h11, 0, 1'b1);
        #(2 * BIT_NS);
        check("ferr_drained", q.size(), 0);

        // Break: one error with 0x00, no re-trigger while held low
        q.push_back('{err: 1'b1, data: 8'h00});
        serial = 1'b0;
        #(25 * BIT_NS);
        check("break_single_event", q.size(), 0);
        serial = 1'b1;
        #(2 * BIT_NS);
        q.push_back('{err: 1'b0, data: 8'h11});
        send_byte(8'h11, 0, 1'b1);
        #(2 * BIT_NS);

        // Reset during data bit 4 of 0x5A
        serial = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            serial = (8'h5A >> i) & 1;
            #(BIT_NS);
        end
        serial = 1'b1;
        #(BIT_NS / 2);
        rst_n = 1'b0;
        #200;
        check("midreset_data", {24'd0, data}, 32'h00);
        check("midreset_valid", {31'd0, valid}, 32'd0);
        check("midreset_ferr", {31'd0, ferr}, 32'd0);
        #(BIT_NS);
        rst_n = 1'b1;
        #(12 * BIT_NS);
        check("after_reset_data", {24'd0, data}, 32'h00);
        q.push_back('{err: 1'b0, data: 8'h77});
        send_byte(8'h77, 0, 1'b1);
        #(3 * BIT_NS);

        check("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
